// File: rtl/stch2dec_window_pkg.sv
// Shared precision constants for the decimal/stochastic converter pair.
// Both directions import this so their output precision cannot drift apart.
package stch2dec_window_pkg;

    localparam int ND_DEFAULT = 8;
    localparam int NW_DEFAULT = 8;
    localparam logic [ND_DEFAULT-1:0] SAT_VALUE = '1;

    // A window of 2^nw samples is rescaled onto an nd-bit fraction.
    function automatic int scale_shift(input int nd, input int nw);
        return nd - nw;
    endfunction

endpackage

// File: rtl/stch2dec_window_win_counter.sv
// Window position and ones count for the stochastic-to-decimal integrator.
// Flags the last enabled sample of each window and presents the final count.
module stch_win_counter #(
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          init,
    input  logic          en,
    input  logic          s,
    output logic          win_end,
    output logic [NW:0]   final_cnt
);

    localparam logic [NW-1:0] W_LAST = '1;

    logic [NW-1:0] w_q, w_d;
    logic [NW:0]   c_q, c_d;

    always_comb begin
        final_cnt = c_q + {{NW{1'b0}}, s};
        win_end   = en && (w_q == W_LAST);
        w_d       = w_q;
        c_d       = c_q;
        // The window boundary restarts the count immediately, so windows are gapless.
        if (win_end) begin
            w_d = '0;
            c_d = '0;
        end else if (en) begin
            w_d = w_q + NW'(1);
            c_d = final_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            w_q <= '0;
            c_q <= '0;
        end else begin
            w_q <= w_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/stch2dec_window.sv
// Integrates a stochastic bit stream over 2^NW enabled cycles and registers the
// result as an ND-bit fraction, with a one-cycle VALID pulse per window.
module stch2dec_window
    import stch2dec_window_pkg::*;
#(
    parameter int ND = ND_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          EN,
    input  logic          S,
    output logic [ND-1:0] D,
    output logic          VALID,
    output logic          SAT
);

    localparam int            SHIFT = scale_shift(ND, NW);
    localparam logic [ND-1:0] SAT_D = '1;

    logic          win_end;
    logic [NW:0]   final_cnt;

    logic [ND-1:0] d_q, d_d;
    logic          valid_q, valid_d;
    logic          sat_q, sat_d;

    stch_win_counter #(.NW(NW)) u_win_counter (
        .clk       (CLK),
        .init      (INIT),
        .en        (EN),
        .s         (S),
        .win_end   (win_end),
        .final_cnt (final_cnt)
    );

    always_comb begin
        d_d     = d_q;
        sat_d   = sat_q;
        valid_d = win_end;
        if (win_end) begin
            // A full window of ones would overflow the fraction; clamp it.
            if (final_cnt[NW]) begin
                d_d   = SAT_D;
                sat_d = 1'b1;
            end else begin
                d_d   = ND'(final_cnt[NW-1:0]) << SHIFT;
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            d_q     <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign D     = d_q;
    assign VALID = valid_q;
    assign SAT   = sat_q;

endmodule

// File: tb/tb_stch2dec_window.sv
// Directed bench for stch2dec_window: an 8/8 instance and an 8/4 instance on shared inputs.
module tb_stch2dec_window;

    logic       CLK = 1'b0;
    logic       INIT = 1'b1;
    logic       EN = 1'b0;
    logic       S = 1'b0;
    logic [7:0] D8, D4;
    logic       VALID8, VALID4, SAT8, SAT4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;

    stch2dec_window #(.ND(8), .NW(8)) dut8 (
        .CLK(CLK), .INIT(INIT), .EN(EN), .S(S), .D(D8), .VALID(VALID8), .SAT(SAT8)
    );

    stch2dec_window #(.ND(8), .NW(4)) dut4 (
        .CLK(CLK), .INIT(INIT), .EN(EN), .S(S), .D(D4), .VALID(VALID4), .SAT(SAT4)
    );

    // Drive one cycle of inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic en_i, input logic s_i);
        EN = en_i;
        S  = s_i;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        INIT = 1'b1;
        step(1'b0, 1'b0);
        INIT = 1'b0;
    endtask

    task automatic test_reset();
        int nvalid;
        INIT = 1'b1;
        step(1'b1, 1'b1);
        n_checks++;
        if (D8 !== 8'd0) begin n_fail++; $display("FAIL reset_d got %0d expected 0", D8); end
        n_checks++;
        if (VALID8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", VALID8); end
        n_checks++;
        if (SAT8 !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b expected 0", SAT8); end
        n_checks++;
        if (D4 !== 8'd0 || VALID4 !== 1'b0 || SAT4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_nw4 got d=%0d v=%b s=%b expected 0/0/0", D4, VALID4, SAT4);
        end
        INIT = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        INIT = 1'b1;
        step(1'b1, 1'b1);
        INIT = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0);
            if (VALID8) nvalid++;
            n_checks++;
            if (VALID8 !== (i == 255)) begin
                n_fail++; $display("FAIL midreset_valid sample %0d got %b expected %b", i + 1, VALID8, (i == 255));
            end
        end
        n_checks++;
        if (nvalid != 1) begin n_fail++; $display("FAIL midreset_pulses got %0d expected 1", nvalid); end
        n_checks++;
        if (D8 !== 8'd0 || SAT8 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_result got d=%0d sat=%b expected 0/0", D8, SAT8);
        end
    endtask

    task automatic test_half_density();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, (i % 2 == 0));
            n_checks++;
            if (VALID8 !== (i == 255)) begin
                n_fail++; $display("FAIL half_valid sample %0d got %b expected %b", i + 1, VALID8, (i == 255));
            end
        end
        n_checks++;
        if (D8 !== 8'd128 || SAT8 !== 1'b0) begin
            n_fail++; $display("FAIL half_result got d=%0d sat=%b expected 128/0", D8, SAT8);
        end
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (D8 !== 8'd128 || VALID8 !== 1'b0) begin
                n_fail++; $display("FAIL half_hold sample %0d got d=%0d v=%b expected 128/0", i + 1, D8, VALID8);
            end
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (D8 !== 8'd0 || VALID8 !== 1'b1) begin
            n_fail++; $display("FAIL half_next got d=%0d v=%b expected 0/1", D8, VALID8);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1);
            n_checks++;
            if (VALID8 !== (i == 255)) begin
                n_fail++; $display("FAIL sat_valid sample %0d got %b expected %b", i + 1, VALID8, (i == 255));
            end
        end
        n_checks++;
        if (D8 !== 8'd255 || SAT8 !== 1'b1) begin
            n_fail++; $display("FAIL sat_result got d=%0d sat=%b expected 255/1", D8, SAT8);
        end
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0);
        n_checks++;
        if (D8 !== 8'd0 || SAT8 !== 1'b0 || VALID8 !== 1'b1) begin
            n_fail++; $display("FAIL sat_clear got d=%0d sat=%b v=%b expected 0/0/1", D8, SAT8, VALID8);
        end
    endtask

    task automatic test_gated_enable();
        int nvalid;
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 512; i++) begin
            step((i % 2 == 0), 1'b1);
            if (VALID8) nvalid++;
            n_checks++;
            if (VALID8 !== (i == 510)) begin
                n_fail++; $display("FAIL gated_valid cycle %0d got %b expected %b", i + 1, VALID8, (i == 510));
            end
        end
        n_checks++;
        if (nvalid != 1) begin n_fail++; $display("FAIL gated_pulses got %0d expected 1", nvalid); end
        n_checks++;
        if (D8 !== 8'd255 || SAT8 !== 1'b1) begin
            n_fail++; $display("FAIL gated_result got d=%0d sat=%b expected 255/1", D8, SAT8);
        end
    endtask

    task automatic test_scaled_window();
        logic one;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            one = ((i % 16) % 3 == 0) && ((i % 16) <= 12);
            step(1'b1, one);
            n_checks++;
            if (VALID4 !== ((i % 16) == 15)) begin
                n_fail++; $display("FAIL scaled_valid sample %0d got %b expected %b", i + 1, VALID4, ((i % 16) == 15));
            end
            if ((i % 16) == 15) begin
                n_checks++;
                if (D4 !== 8'd80 || SAT4 !== 1'b0) begin
                    n_fail++; $display("FAIL scaled_result sample %0d got d=%0d sat=%b expected 80/0", i + 1, D4, SAT4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ones [3] = '{64, 192, 0};
        logic [7:0] exp_d [3] = '{8'd64, 8'd192, 8'd0};
        int nvalid;
        int last_cyc;
        do_reset();
        nvalid   = 0;
        last_cyc = -1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 256; i++) begin
                step(1'b1, (i < ones[w]));
                if (VALID8) begin
                    if (last_cyc >= 0) begin
                        n_checks++;
                        if (cyc - last_cyc != 256) begin
                            n_fail++; $display("FAIL b2b_spacing got %0d expected 256", cyc - last_cyc);
                        end
                    end
                    last_cyc = cyc;
                    nvalid++;
                end
            end
            n_checks++;
            if (D8 !== exp_d[w] || VALID8 !== 1'b1) begin
                n_fail++; $display("FAIL b2b_window%0d got d=%0d v=%b expected %0d/1", w, D8, VALID8, exp_d[w]);
            end
        end
        n_checks++;
        if (nvalid != 3) begin n_fail++; $display("FAIL b2b_pulses got %0d expected 3", nvalid); end
    endtask

    initial begin
        test_reset();
        test_half_density();
        test_saturation();
        test_gated_enable();
        test_scaled_window();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stch2dec_window.md
Name: stch2dec_window

Overview:
- Downstream stage of the decimal-to-stochastic converter: integrates a stochastic bit stream back into an ND-bit decimal probability (x/2^ND).
- Counts the 1s in S over a fixed window of 2^NW enabled cycles, then registers the scaled count and pulses VALID.
- Used at network outputs and in test harnesses to read back stochastic neuron results.

Parameters:
- ND, 8, precision of output decimal fraction (matches converter precision).
- NW, 8, log2 of window length in enabled cycles; legal range 1..ND.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- INIT  input  1  synchronous, active-high reset.
- EN  input  1  sample enable; S is counted only on cycles with EN=1.
- S  input  1  stochastic bit stream.
- D  output  ND  decimal result of last completed window, scaled to x/2^ND.
- VALID  output  1  one-cycle pulse: D updated this cycle.
- SAT  output  1  last completed window was all ones; D clamped to 2^ND-1.

Behaviour:
- Internal state:
  - window counter W, NW bits;
  - ones counter C, NW+1 bits, range 0..2^NW.
- Reset (INIT=1 at a rising edge): W=0, C=0, D=0, VALID=0, SAT=0.
  - INIT has priority over EN.
  - INIT mid-window discards the partial count; the next window starts on the first EN cycle after INIT deasserts.
- EN=0: W, C, D and SAT hold; VALID=0. S is ignored.
- EN=1 and W≠2^NW-1: W<=W+1; C<=C+S; VALID<=0.
- EN=1 and W=2^NW-1 (last sample of the window):
  - Final count F = C+S, range 0..2^NW.
  - If F=2^NW: D<=2^ND-1, SAT<=1.
  - Else: D<=F<<(ND-NW), SAT<=0.
  - VALID<=1; W<=0; C<=0. No gap: the next window starts on the next EN cycle.
- Latency: D, SAT and VALID are registered on the same edge that samples the final bit, so they are visible in the cycle immediately after.
- VALID is high for exactly one cycle per completed window. Windows complete every 2^NW EN cycles, with no slips when EN is noncontiguous.
- D and SAT hold between windows. D is never in a partial state.
- W wraps from 2^NW-1 to 0 only via the window-end rule. C can never exceed 2^NW.
- Arithmetic is unsigned throughout. The left shift is zero-fill; with NW=ND there is no shift.
- Reset values are chosen so that D=0 and VALID=0 before the first window completes.

Decomposition:
- Shared package constants:
  - default ND=8, NW=8;
  - SAT_VALUE = 2^ND-1.
  - The package is shared with the decimal-to-stochastic converter so precision stays consistent.
- One natural sub-module: stch_win_counter.
  - Holds W and C; outputs the window-end flag and F.
  - stch2dec_window adds the scale/saturate logic and the output registers on top.

Test Plan:
- Reset mid-window:
  - ND=NW=8, EN=1, S=1 for 100 cycles, then INIT for 1 cycle, then S=0 for 256 cycles.
  - Required: VALID pulses once, at cycle 256 after INIT; D=0; SAT=0; the 100 pre-reset ones are not counted.
- Half density:
  - ND=NW=8, EN=1, S alternating 1,0 for 256 cycles.
  - Required: VALID high for one cycle after sample 256; D=128; SAT=0; D holds 128 until the next window ends.
- Saturation:
  - ND=NW=8, EN=1, S=1 for 256 cycles.
  - Required: D=255, SAT=1, VALID pulse.
  - Next window with S=0: D=0, SAT=0.
- Gated enable:
  - ND=NW=8, S=1, EN toggling 1,0 for 512 cycles.
  - Required: exactly one VALID, after the 256th enabled sample (cycle 511); D=255, SAT=1.
  - VALID never asserts on an EN=0 cycle.
- Scaled short window:
  - ND=8, NW=4, EN=1, S=1 on 5 of 16 cycles.
  - Required: D=80 (5<<4), SAT=0, VALID every 16 cycles with no gap between windows.
- Back-to-back windows:
  - ND=NW=8, three consecutive windows with 64, 192 and 0 ones.
  - Required: D sequence 64, 192, 0; VALID pulses exactly 256 cycles apart.
